// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver.
// Samples rx_in on a 16x oversample tick and runs a frame FSM:
// start bit, 7/8 data bits (LSB first), optional parity, 1/2 stop bits.
// Optional feature macro: UART_RX_SYNC_EN adds a 2-flop input synchronizer.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx_in,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop_bits,
  input  logic       data_width,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_e;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            armed_q, armed_d;
  logic [7:0]      shift_q, shift_d;
  logic            ptype_q, ptype_d;
  logic            pen_q, pen_d;
  logic            stop2_q, stop2_d;
  logic            w8_q, w8_d;
  logic            pflag_q, pflag_d;
  logic            fflag_q, fflag_d;
  logic [7:0]      dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      armed_q  <= 1'b0;
      shift_q  <= '0;
      ptype_q  <= 1'b0;
      pen_q    <= 1'b0;
      stop2_q  <= 1'b0;
      w8_q     <= 1'b0;
      pflag_q  <= 1'b0;
      fflag_q  <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      armed_q  <= armed_d;
      shift_q  <= shift_d;
      ptype_q  <= ptype_d;
      pen_q    <= pen_d;
      stop2_q  <= stop2_d;
      w8_q     <= w8_d;
      pflag_q  <= pflag_d;
      fflag_q  <= fflag_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  logic [7:0] aligned;
  logic       complete;

  // Next-state logic: everything advances on tick except the data_valid clear
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    armed_d  = armed_q;
    shift_d  = shift_q;
    ptype_d  = ptype_q;
    pen_d    = pen_q;
    stop2_d  = stop2_q;
    w8_d     = w8_q;
    pflag_d  = pflag_q;
    fflag_d  = fflag_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    complete = 1'b0;
    // 7-bit frames end up in shift[7:1] of the right-shifting register
    aligned  = w8_q ? shift_q : {1'b0, shift_q[7:1]};

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cnt_d   = '0;
            armed_d = 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == MID) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              cnt_d   = '0;
              bit_d   = '0;
              ptype_d = parity_type;
              pen_d   = parity_en;
              stop2_d = stop_bits;
              w8_d    = data_width;
              pflag_d = 1'b0;
              fflag_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            case (state_q)
              S_DATA: begin
                shift_d = {rx_s, shift_q[7:1]};
                if (bit_q == (w8_q ? 3'd7 : 3'd6)) begin
                  bit_d   = '0;
                  state_d = pen_q ? S_PARITY : S_STOP1;
                end else begin
                  bit_d = bit_q + 3'd1;
                end
              end
              S_PARITY: begin
                if (rx_s != ((^aligned) ^ ptype_q)) pflag_d = 1'b1;
                state_d = S_STOP1;
              end
              S_STOP1: begin
                if (!rx_s) fflag_d = 1'b1;
                if (stop2_q) state_d = S_STOP2;
                else         complete = 1'b1;
              end
              S_STOP2: begin
                if (!rx_s) fflag_d = 1'b1;
                complete = 1'b1;
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase

      if (complete) begin
        state_d  = S_IDLE;
        armed_d  = rx_s;
        dout_d   = aligned;
        dvalid_d = 1'b1;
        perr_d   = pflag_q;
        ferr_d   = fflag_q | ~rx_s;
      end
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive datapath for the UART, and the counterpart of the transmit frame builder. It samples the serial line with a 16x oversampling enable and runs a frame FSM: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits. It presents the received byte with parity and framing status. It sits between the pad-side `rx` line and the UART register/FIFO layer, with the same frame-format controls as the transmitter.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 4.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  oversample enable, one `clk` wide, at `OVERSAMPLE` × baud rate.
- `rx_in`  in  1  serial line; idles at 1.
- `parity_type`  in  1  0 = even, 1 = odd. Matches transmitter parity bit = ^data XOR parity_type.
- `parity_en`  in  1  parity bit present.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `data_width`  in  1  0 = 7 data bits, 1 = 8 data bits.
- `data_out`  out  8  last received byte; bit 7 is forced to 0 in 7-bit mode.
- `data_valid`  out  1  one-`clk` pulse when a frame completes.
- `parity_err`  out  1  parity mismatch of the last frame; valid with and held after `data_valid`.
- `frame_err`  out  1  a sampled stop bit was 0 in the last frame; held like `parity_err`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Tick counter `cnt` is `$clog2(OVERSAMPLE)` wide. Bit counter is 3 bits.
- All state changes, counter updates and samples happen only on `clk` edges where `tick` = 1, except the `data_valid` clear.
- **IDLE:**
  - An `armed` flag sets on any tick with `rx_in` = 1.
  - On a tick with `rx_in` = 0 and `armed` = 1: go to START, set `cnt` = 0, clear `armed`.
  - The line must return high after a break before a new start is accepted.
- **START:** at `cnt` = `OVERSAMPLE`/2 − 1 (mid-bit), re-sample.
  - If 1: false start, return to IDLE.
  - If 0: set `cnt` = 0, go to DATA.
  - Latch `parity_type`, `parity_en`, `stop_bits` and `data_width` here. Changes mid-frame have no effect.
- **DATA, PARITY, STOP1, STOP2:** sample when `cnt` = `OVERSAMPLE` − 1, then reset `cnt` to 0. Each sample is therefore one bit period after the previous mid-bit sample.
- **DATA:**
  - Shift the sample into a right-shifting register, LSB first.
  - After 7 or 8 samples go to PARITY if `parity_en`, else to STOP1.
  - In 7-bit mode, align so that `data_out[6:0]` holds the data and `data_out[7]` = 0.
- **PARITY:** expected bit = (^received 8-bit value, bit 7 = 0 in 7-bit mode) XOR `parity_type`. A mismatch sets the internal parity flag.
- **STOP1:** a sample of 0 sets the internal frame flag. Go to STOP2 if `stop_bits`, else complete.
- **STOP2:** a sample of 0 sets the internal frame flag, then complete.
- **Complete:**
  - On the `clk` edge of the final stop sample, register `data_out`, `parity_err` and `frame_err`.
  - Assert `data_valid` for exactly that following cycle.
  - Return to IDLE with `armed` = (final stop sample == 1).
  - Errored frames still deliver data, with the flags set.
- With `parity_en` = 0, `parity_err` updates to 0 at each completion.

## Timing
- Reset values:
  - state IDLE, `armed` 0, all counters 0;
  - `data_out` 8'h00, `data_valid` 0, `parity_err` 0, `frame_err` 0, `busy` 0.
- Asserting reset mid-frame aborts immediately; no `data_valid` is produced for that frame.
- `data_valid` rises one `clk` after the tick edge that samples the final stop bit. It is never asserted for two consecutive cycles.
- `busy` rises one `clk` after the start-detect tick. It falls on the same edge on which `data_valid` rises.
- Line to output latency, measured from the falling start edge, is about (1 + data bits + parity + stop bits − 0.5) bit periods.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx_in` passes through a 2-flop synchronizer, reset to 1, before the FSM.
  - All sample points shift 2 `clk` later.
- Undefined: `rx_in` is used directly and must already be synchronous to `clk`.
- Behaviour at tick granularity is otherwise identical.

## Test plan
- **Basic frame:** 8N1, byte 8'hA5 → `data_out` = 8'hA5, one `data_valid` pulse, both error flags 0, `busy` high throughout the frame.
- **Parity:** 7E2, byte 7'h41 with correct even parity bit 0 → `data_out` = 8'h41, `parity_err` 0. Repeat with the parity bit flipped → `parity_err` 1, `data_out` still 8'h41.
- **Odd parity, second stop bit:** 8O2, 8'hFF with the second stop bit driven 0 → `frame_err` 1, `parity_err` 0, `data_valid` pulses once.
- **False start:** glitch of 0 lasting 3 ticks → returns to IDLE, no `data_valid`. A valid 8'h3C frame immediately after is received correctly.
- **Break:** line held 0 for 20 bit periods → exactly one frame reported (8'h00, `frame_err` 1). No further frames until the line is high for at least one tick; the next frame 8'h5A is received.
- **Reset mid-frame:** assert `rst_n` = 0 during DATA bit 4 → all outputs return to reset values, no `data_valid`. After release, 8'h81 is received correctly.
